// File: rtl/eth_tx_frame_gen.sv
// Ethernet test-frame generator feeding the 10G MAC transmit AXI-Stream.
// Each frame is DST MAC, SRC MAC, EtherType, then an incrementing-byte payload; the MAC adds FCS.
module eth_tx_frame_gen #(
   parameter logic [47:0] P_DST_MAC  = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] P_SRC_MAC  = 48'h000A_3501_0203,
   parameter logic [15:0] P_ETH_TYPE = 16'h88B5
) (
   input  logic        i_xgmii_clk,
   input  logic        i_xgmii_rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [15:0] i_frame_len,
   input  logic [15:0] i_frame_num,
   input  logic [7:0]  i_gap,
   output logic [63:0] m_axis_tdata,
   output logic [31:0] m_axis_tuser,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        o_busy,
   output logic [31:0] o_frame_cnt
);

   // state | meaning
   // IDLE  | no run active, outputs quiet
   // SEND  | streaming beats of the current frame
   // GAP   | idle cycles between frames, counting down
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t      state, state_next;
   logic [15:0] num_lat;
   logic [7:0]  gap_lat;
   logic [7:0]  gap_cnt;
   logic [10:0] len_lat;
   logic [10:0] len_clamped;
   logic [7:0]  beat_cnt;
   logic [7:0]  last_beat;
   logic        stop_pend;
   logic        stop_now;
   logic [31:0] frame_cnt;
   logic [31:0] cnt_inc;
   logic        send_active;
   logic        hs;
   logic        is_last;
   logic        frame_done;
   logic        run_done;

   function automatic logic [7:0] frame_byte(input logic [10:0] idx);
      logic [7:0] b;
      b = 8'(idx - 11'd14);
      if (idx < 11'd14) begin
         case (idx[3:0])
            4'd0:    b = P_DST_MAC[47:40];
            4'd1:    b = P_DST_MAC[39:32];
            4'd2:    b = P_DST_MAC[31:24];
            4'd3:    b = P_DST_MAC[23:16];
            4'd4:    b = P_DST_MAC[15:8];
            4'd5:    b = P_DST_MAC[7:0];
            4'd6:    b = P_SRC_MAC[47:40];
            4'd7:    b = P_SRC_MAC[39:32];
            4'd8:    b = P_SRC_MAC[31:24];
            4'd9:    b = P_SRC_MAC[23:16];
            4'd10:   b = P_SRC_MAC[15:8];
            4'd11:   b = P_SRC_MAC[7:0];
            4'd12:   b = P_ETH_TYPE[15:8];
            default: b = P_ETH_TYPE[7:0];
         endcase
      end
      return b;
   endfunction

   always_comb begin
      if (i_frame_len < 16'd60)
         len_clamped = 11'd60;
      else if (i_frame_len > 16'd1514)
         len_clamped = 11'd1514;
      else
         len_clamped = i_frame_len[10:0];
   end

   assign send_active = (state == S_SEND);
   assign last_beat   = 8'((len_lat - 11'd1) >> 3);
   assign hs          = send_active && m_axis_tready;
   assign is_last     = (beat_cnt == last_beat);
   assign frame_done  = hs && is_last;
   assign cnt_inc     = (frame_cnt == 32'hFFFF_FFFF) ? frame_cnt : frame_cnt + 32'd1;
   // A stop arriving on the tlast cycle itself is treated as already pending.
   assign stop_now    = stop_pend | i_stop;
   assign run_done    = stop_now || ((num_lat != 16'd0) && (cnt_inc == {16'd0, num_lat}));

   always_ff @(posedge i_xgmii_clk) begin
      if (i_xgmii_rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (i_start)
               state_next = S_SEND;
         end
         S_SEND: begin
            if (frame_done) begin
               if (run_done)
                  state_next = S_IDLE;
               else if (gap_lat == 8'd0)
                  state_next = S_SEND;
               else
                  state_next = S_GAP;
            end
         end
         S_GAP: begin
            if (stop_now)
               state_next = S_IDLE;
            else if (gap_cnt == 8'd1)
               state_next = S_SEND;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_xgmii_clk) begin
      if (i_xgmii_rst) begin
         num_lat   <= '0;
         gap_lat   <= '0;
         gap_cnt   <= '0;
         len_lat   <= '0;
         beat_cnt  <= '0;
         stop_pend <= 1'b0;
         frame_cnt <= '0;
      end else begin
         stop_pend <= (state_next == S_IDLE) ? 1'b0 : stop_now;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  num_lat   <= i_frame_num;
                  gap_lat   <= i_gap;
                  frame_cnt <= '0;
                  len_lat   <= len_clamped;
                  beat_cnt  <= '0;
               end
            end
            S_SEND: begin
               if (hs) begin
                  if (is_last) begin
                     frame_cnt <= cnt_inc;
                     beat_cnt  <= '0;
                     gap_cnt   <= gap_lat;
                     if (state_next == S_SEND)
                        len_lat <= len_clamped;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            S_GAP: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (state_next == S_SEND)
                  len_lat <= len_clamped;
            end
            default: ;
         endcase
      end
   end

   // Beat contents are a pure function of beat_cnt and len_lat, so they hold while stalled.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tvalid = send_active;
      m_axis_tlast  = send_active && is_last;
      m_axis_tuser  = send_active ? {21'd0, len_lat} : 32'd0;
      o_busy        = (state != S_IDLE);
      o_frame_cnt   = frame_cnt;
      for (int n = 0; n < 8; n++) begin
         if (send_active && ({beat_cnt, 3'(n)} < len_lat)) begin
            m_axis_tkeep[n]         = 1'b1;
            m_axis_tdata[8*n +: 8]  = frame_byte({beat_cnt, 3'(n)});
         end
      end
   end

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Directed bench for eth_tx_frame_gen: framing, clamping, gaps, backpressure, stop and reset.
module tb_eth_tx_frame_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic        i_stop;
   logic [15:0] i_frame_len;
   logic [15:0] i_frame_num;
   logic [7:0]  i_gap;
   logic [63:0] m_axis_tdata;
   logic [31:0] m_axis_tuser;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        o_busy;
   logic [31:0] o_frame_cnt;

   int tests = 0;
   int fails = 0;

   logic [63:0] cap_data [0:255];
   logic [7:0]  cap_keep [0:255];
   logic [31:0] last_user;

   localparam logic [111:0] HDR = {48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h88B5};

   always #3 clk = ~clk;

   eth_tx_frame_gen dut (
      .i_xgmii_clk   (clk),
      .i_xgmii_rst   (rst),
      .i_start       (i_start),
      .i_stop        (i_stop),
      .i_frame_len   (i_frame_len),
      .i_frame_num   (i_frame_num),
      .i_gap         (i_gap),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .o_busy        (o_busy),
      .o_frame_cnt   (o_frame_cnt)
   );

   function automatic logic [7:0] model_byte(input int idx);
      logic [111:0] h;
      h = HDR;
      if (idx < 14)
         return h[111 - 8*idx -: 8];
      return 8'((idx - 14) % 256);
   endfunction

   task automatic start_run(input int len, input int num, input int gap, input bit stop);
      @(negedge clk);
      i_frame_len = 16'(len);
      i_frame_num = 16'(num);
      i_gap       = 8'(gap);
      i_start     = 1'b1;
      i_stop      = stop;
      @(negedge clk);
      i_start = 1'b0;
      i_stop  = 1'b0;
   endtask

   // Called at a negedge where beat 0 of the frame is already presented.
   task automatic recv_frame(input int len, input bit rnd, input int stop_at, output int nbeats);
      logic [63:0] exp_d;
      logic [7:0]  exp_k;
      logic [63:0] hd;
      logic [7:0]  hk;
      logic        hl;
      logic [31:0] hu;
      bit          stalled;
      bit          done;
      int          beat;
      int          cyc;
      int          nb;
      stalled = 0; done = 0; beat = 0; cyc = 0;
      hd = '0; hk = '0; hl = 1'b0; hu = '0;
      nb = (len + 7) / 8;
      while (!done) begin
         if (cyc >= 4000) begin
            tests++; fails++;
            $display("FAIL recv_timeout: got %0d beats, exp %0d", beat, nb);
            done = 1;
         end else begin
            if (stalled) begin
               tests++;
               if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tkeep !== hk ||
                   m_axis_tlast !== hl || m_axis_tuser !== hu) begin
                  fails++;
                  $display("FAIL stall_hold beat %0d: got v=%b d=%h k=%h, exp v=1 d=%h k=%h",
                           beat, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, hd, hk);
               end
            end
            if (m_axis_tvalid === 1'b1) begin
               m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               i_stop        = (beat == stop_at);
               if (m_axis_tready) begin
                  exp_d = '0;
                  exp_k = '0;
                  for (int n = 0; n < 8; n++) begin
                     if (beat*8 + n < len) begin
                        exp_k[n]        = 1'b1;
                        exp_d[8*n +: 8] = model_byte(beat*8 + n);
                     end
                  end
                  tests++;
                  if (m_axis_tdata !== exp_d || m_axis_tkeep !== exp_k ||
                      m_axis_tlast !== (beat == nb - 1) || m_axis_tuser !== 32'(len)) begin
                     fails++;
                     $display("FAIL beat_%0d: got d=%h k=%h l=%b u=%0d, exp d=%h k=%h l=%b u=%0d",
                              beat, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                              exp_d, exp_k, (beat == nb - 1), len);
                  end
                  cap_data[beat[7:0]] = m_axis_tdata;
                  cap_keep[beat[7:0]] = m_axis_tkeep;
                  last_user = m_axis_tuser;
                  if (m_axis_tlast === 1'b1 || beat >= nb - 1 || beat >= 255) done = 1;
                  beat++;
                  stalled = 0;
               end else begin
                  stalled = 1;
                  hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast; hu = m_axis_tuser;
               end
            end else if (beat > 0) begin
               tests++; fails++;
               $display("FAIL valid_drop at beat %0d: got tvalid=%b, exp 1", beat, m_axis_tvalid);
               done = 1;
            end
            if (!done) begin
               @(negedge clk);
               cyc++;
            end
         end
      end
      nbeats = beat;
   endtask

   task automatic count_gap(output int g);
      g = 0;
      @(negedge clk);
      while (m_axis_tvalid !== 1'b1 && g < 1000) begin
         g++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b exp 0", m_axis_tvalid); end
      tests++; if (m_axis_tdata !== 64'd0) begin fails++; $display("FAIL rst_tdata: got %h exp 0", m_axis_tdata); end
      tests++; if (m_axis_tkeep !== 8'd0) begin fails++; $display("FAIL rst_tkeep: got %h exp 0", m_axis_tkeep); end
      tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b exp 0", m_axis_tlast); end
      tests++; if (m_axis_tuser !== 32'd0) begin fails++; $display("FAIL rst_tuser: got %h exp 0", m_axis_tuser); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", o_busy); end
      tests++; if (o_frame_cnt !== 32'd0) begin fails++; $display("FAIL rst_frame_cnt: got %0d exp 0", o_frame_cnt); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_min_frame();
      int nb;
      start_run(60, 1, 0, 1'b0);
      tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL first_beat_latency: got tvalid=%b exp 1", m_axis_tvalid); end
      tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL busy_set: got %b exp 1", o_busy); end
      recv_frame(60, 1'b0, -1, nb);
      tests++; if (nb != 8) begin fails++; $display("FAIL min_beats: got %0d exp 8", nb); end
      tests++; if (cap_data[0] !== 64'h0A00_FFFF_FFFF_FFFF) begin fails++; $display("FAIL min_beat0: got %h exp 0a00ffffffffffff", cap_data[0]); end
      tests++; if (cap_data[1] !== 64'h0100_B588_0302_0135) begin fails++; $display("FAIL min_beat1: got %h exp 0100b58803020135", cap_data[1]); end
      tests++; if (cap_data[7] !== 64'h0000_0000_2D2C_2B2A) begin fails++; $display("FAIL min_beat7: got %h exp 000000002d2c2b2a", cap_data[7]); end
      tests++; if (cap_keep[7] !== 8'h0F) begin fails++; $display("FAIL min_keep7: got %h exp 0f", cap_keep[7]); end
      tests++; if (last_user !== 32'd60) begin fails++; $display("FAIL min_tuser: got %0d exp 60", last_user); end
      @(negedge clk);
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL min_busy_fall: got %b exp 0", o_busy); end
      tests++; if (o_frame_cnt !== 32'd1) begin fails++; $display("FAIL min_frame_cnt: got %0d exp 1", o_frame_cnt); end
      tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL min_idle_valid: got %b exp 0", m_axis_tvalid); end
   endtask

   task automatic test_gap();
      int nb;
      int g;
      start_run(64, 3, 4, 1'b0);
      for (int f = 0; f < 3; f++) begin
         recv_frame(64, 1'b0, -1, nb);
         tests++; if (nb != 8) begin fails++; $display("FAIL gap_beats f%0d: got %0d exp 8", f, nb); end
         tests++; if (cap_keep[7] !== 8'hFF) begin fails++; $display("FAIL gap_keep7 f%0d: got %h exp ff", f, cap_keep[7]); end
         if (f < 2) begin
            count_gap(g);
            tests++; if (g != 4) begin fails++; $display("FAIL gap_len f%0d: got %0d exp 4", f, g); end
         end
      end
      @(negedge clk);
      tests++; if (o_frame_cnt !== 32'd3) begin fails++; $display("FAIL gap_frame_cnt: got %0d exp 3", o_frame_cnt); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL gap_busy: got %b exp 0", o_busy); end
   endtask

   task automatic test_clamp();
      int nb;
      start_run(30, 1, 0, 1'b0);
      recv_frame(60, 1'b0, -1, nb);
      tests++; if (nb != 8) begin fails++; $display("FAIL clamp_lo_beats: got %0d exp 8", nb); end
      tests++; if (last_user !== 32'd60) begin fails++; $display("FAIL clamp_lo_tuser: got %0d exp 60", last_user); end
      @(negedge clk);
      start_run(2000, 1, 0, 1'b0);
      recv_frame(1514, 1'b0, -1, nb);
      tests++; if (nb != 190) begin fails++; $display("FAIL clamp_hi_beats: got %0d exp 190", nb); end
      tests++; if (last_user !== 32'd1514) begin fails++; $display("FAIL clamp_hi_tuser: got %0d exp 1514", last_user); end
      tests++; if (cap_keep[189] !== 8'h03) begin fails++; $display("FAIL clamp_hi_keep: got %h exp 03", cap_keep[189]); end
      tests++; if (cap_data[33][55:48] !== 8'h00) begin fails++; $display("FAIL payload_wrap256: got %h exp 00", cap_data[33][55:48]); end
      tests++; if (cap_data[33][47:40] !== 8'hFF) begin fails++; $display("FAIL payload_255: got %h exp ff", cap_data[33][47:40]); end
      @(negedge clk);
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL clamp_busy: got %b exp 0", o_busy); end
   endtask

   task automatic test_random_ready();
      int nb;
      int g;
      start_run(100, 2, 2, 1'b0);
      recv_frame(100, 1'b1, -1, nb);
      tests++; if (nb != 13) begin fails++; $display("FAIL rnd_beats f0: got %0d exp 13", nb); end
      tests++; if (cap_keep[12] !== 8'h0F) begin fails++; $display("FAIL rnd_keep12: got %h exp 0f", cap_keep[12]); end
      m_axis_tready = 1'b1;
      count_gap(g);
      recv_frame(100, 1'b1, -1, nb);
      tests++; if (nb != 13) begin fails++; $display("FAIL rnd_beats f1: got %0d exp 13", nb); end
      m_axis_tready = 1'b1;
      @(negedge clk);
      tests++; if (o_frame_cnt !== 32'd2) begin fails++; $display("FAIL rnd_frame_cnt: got %0d exp 2", o_frame_cnt); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rnd_busy: got %b exp 0", o_busy); end
   endtask

   task automatic test_back_to_back();
      int nb;
      start_run(64, 0, 0, 1'b0);
      recv_frame(64, 1'b0, -1, nb);
      @(negedge clk);
      tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL b2b_no_gap: got tvalid=%b exp 1", m_axis_tvalid); end
      tests++; if (o_frame_cnt !== 32'd1) begin fails++; $display("FAIL b2b_cnt1: got %0d exp 1", o_frame_cnt); end
      recv_frame(64, 1'b0, 3, nb);
      tests++; if (nb != 8) begin fails++; $display("FAIL stop_no_truncate: got %0d beats exp 8", nb); end
      @(negedge clk);
      tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL stop_valid: got %b exp 0", m_axis_tvalid); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL stop_busy: got %b exp 0", o_busy); end
      tests++; if (o_frame_cnt !== 32'd2) begin fails++; $display("FAIL stop_frame_cnt: got %0d exp 2", o_frame_cnt); end
      repeat (3) @(negedge clk);
      tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL stop_stays_idle: got %b exp 0", m_axis_tvalid); end
   endtask

   task automatic test_start_stop_same();
      int nb;
      start_run(64, 0, 0, 1'b1);
      recv_frame(64, 1'b0, -1, nb);
      @(negedge clk);
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL startstop_busy: got %b exp 0", o_busy); end
      tests++; if (o_frame_cnt !== 32'd1) begin fails++; $display("FAIL startstop_cnt: got %0d exp 1", o_frame_cnt); end
   endtask

   task automatic test_reset_mid();
      int nb;
      start_run(64, 0, 0, 1'b0);
      recv_frame(64, 1'b0, -1, nb);
      repeat (4) @(negedge clk);
      tests++; if (m_axis_tdata !== 64'h1110_0F0E_0D0C_0B0A) begin fails++; $display("FAIL mid_beat3: got %h exp 11100f0e0d0c0b0a", m_axis_tdata); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b exp 0", m_axis_tvalid); end
      tests++; if (o_frame_cnt !== 32'd0) begin fails++; $display("FAIL midrst_cnt: got %0d exp 0", o_frame_cnt); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b exp 0", o_busy); end
      rst = 1'b0;
      start_run(64, 1, 0, 1'b0);
      tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0A00_FFFF_FFFF_FFFF) begin
         fails++; $display("FAIL post_rst_beat0: got v=%b d=%h exp v=1 d=0a00ffffffffffff", m_axis_tvalid, m_axis_tdata);
      end
      recv_frame(64, 1'b0, -1, nb);
      @(negedge clk);
      tests++; if (o_busy !== 1'b0 || o_frame_cnt !== 32'd1) begin
         fails++; $display("FAIL post_rst_done: got busy=%b cnt=%0d exp busy=0 cnt=1", o_busy, o_frame_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
      i_frame_len = 16'd0; i_frame_num = 16'd0; i_gap = 8'd0;
      m_axis_tready = 1'b1; last_user = '0;
      test_reset();
      test_min_frame();
      test_gap();
      test_clamp();
      test_random_ready();
      test_back_to_back();
      test_start_stop_same();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion, exp finish before 300000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/eth_tx_frame_gen.md
Name: eth_tx_frame_gen

Overview:
- Synthesizable Ethernet test-frame generator on the MAC transmit side; drives the 10G MAC's s_axis_t* AXI-Stream input, whose tready backpressures this block.
- Builds frames of: destination MAC, source MAC, EtherType, then an incrementing-byte payload. The MAC appends the FCS.
- Frame length, frame count and inter-frame gap are runtime-programmable. Used for link bring-up and for the loopback throughput test.

Parameters:
- P_DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC; byte [47:40] is transmitted first.
- P_SRC_MAC, 48'h000A_3501_0203, source MAC; byte [47:40] is transmitted first.
- P_ETH_TYPE, 16'h88B5, EtherType; byte [15:8] is transmitted first.

Ports:
- i_xgmii_clk  in  1  156.25 MHz XGMII clock.
- i_xgmii_rst  in  1  Reset. Synchronous, active-high.
- i_start  in  1  Single-cycle pulse; starts a run. Ignored while o_busy=1.
- i_stop  in  1  Pulse; ends the run after the current frame completes.
- i_frame_len  in  16  Frame bytes excluding FCS. Sampled at each frame start.
- i_frame_num  in  16  Frames per run; 0 = continuous. Sampled on i_start.
- i_gap  in  8  Idle cycles between frames. Sampled on i_start.
- m_axis_tdata  out  64  Byte n is carried on [8n+7:8n]; byte 0 is first on the wire.
- m_axis_tuser  out  32  {16'd0, effective frame length}; held constant for the whole frame.
- m_axis_tkeep  out  8  Bit n marks byte n valid.
- m_axis_tlast  out  1  Marks the last beat of a frame.
- m_axis_tvalid  out  1  Beat valid.
- m_axis_tready  in  1  Sink ready.
- o_busy  out  1  High from start acceptance until the run ends.
- o_frame_cnt  out  32  Frames completed (tlast handshakes) in the current run.

Behaviour:
- Reset: all outputs are 0; FSM enters IDLE. Reset mid-frame aborts the frame immediately; tvalid drops in the cycle after reset is sampled.
- FSM states: IDLE, SEND, GAP.
- IDLE -> SEND: on i_start. Same cycle: latch i_frame_num and i_gap, clear o_frame_cnt, set o_busy.
- SEND, effective length L: i_frame_len clamped to [60,1514], latched on entry to SEND.
  - Beats = ceil(L/8); beat counter starts at 0.
  - Beat 0, bytes 0-5: P_DST_MAC. Bytes 6-7: P_SRC_MAC[47:32].
  - Beat 1, bytes 8-11: P_SRC_MAC[31:0]. Bytes 12-13: P_ETH_TYPE. Bytes 14-15: payload.
  - Payload byte k (frame byte 14+k) = k[7:0], wrapping at 256.
  - Last beat: tkeep = (L mod 8 == 0) ? 8'hFF : (8'h01 << (L mod 8)) - 1. Invalid lanes carry 8'h00.
  - All other beats: tkeep = 8'hFF.
- Handshake (AXI-Stream rules):
  - A beat transfers when tvalid && tready.
  - While tvalid=1 and tready=0, tdata, tkeep, tlast and tuser are held stable.
  - tvalid never deasserts mid-frame.
  - Nothing (output or state) advances on cycles where tready=0.
- At the tlast handshake, o_frame_cnt increments (saturates at 32'hFFFF_FFFF). Next state is chosen as:
  - Stop pending, or i_frame_num≠0 and count reaches i_frame_num: go to IDLE and clear o_busy the next cycle.
  - Otherwise, i_gap=0: stay in SEND; the next frame's beat 0 is valid the next cycle (back-to-back).
  - Otherwise: go to GAP with tvalid=0 for exactly i_gap cycles, then SEND.
- i_stop:
  - Sets a stop-pending flag. Pending stop is honoured at the next frame boundary. A frame is never truncated.
  - In GAP: go to IDLE the next cycle.
  - In IDLE: no effect.
  - i_stop and i_start in the same cycle in IDLE: start wins, and stop is applied at the first frame end.
- Latency: first beat of a run is valid 1 cycle after i_start is sampled.
- Throughput: 1 beat per cycle while tready=1.

Test Plan:
- L=60, frame_num=1, gap=0, tready=1:
  - 8 beats.
  - beat0 = 64'h0A00_FFFF_FFFF_FFFF.
  - beat1 = 64'h0100_B588_0302_0135.
  - beat7: tkeep=8'h0F, tlast=1, tuser=32'd60.
  - o_frame_cnt=1; o_busy falls.
- L=64, frame_num=3, gap=4:
  - Each frame is 8 beats; last tkeep=8'hFF.
  - Exactly 4 tvalid=0 cycles between frames.
  - o_frame_cnt ends at 3.
- L=30 (clamped to 60) and L=2000 (clamped to 1514):
  - tuser = 60 and 1514 respectively.
  - 1514 case: 190 beats, last tkeep=8'h03; payload byte 256 reads 8'h00.
- Random tready at 50% duty:
  - Held beats never change while stalled.
  - Payload matches the model; beat count is unchanged.
- Continuous run (frame_num=0, gap=0):
  - Back-to-back frames with no tvalid gap.
  - i_stop mid-frame: the frame completes, then tvalid=0 and o_busy=0.
- Reset asserted on beat 3 of a frame:
  - Next cycle: tvalid=0, o_frame_cnt=0, o_busy=0.
  - A subsequent i_start produces beat0 = 64'h0A00_FFFF_FFFF_FFFF.
